// File: rtl/spram_fifo_ctrl.sv
// FIFO controller driving an external single-port RAM with a
// registered output word; each RAM cycle is either a read or a write.
module spram_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  push_valid,
    output logic                  push_ready,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic                  pop_valid,
    input  logic                  pop_ready,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = 1;
    localparam logic [CW-1:0] CNT_ONE = 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        OP_IDLE,
        OP_READ,
        OP_WRITE
    } op_e;

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         ram_cnt_q, ram_cnt_d;
    logic                  rd_pend_q, rd_pend_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] pop_data_q, pop_data_d;

    logic pop_fire;
    logic push_fire;
    logic rd_issue;
    op_e  op;

    always_comb begin
        pop_fire   = out_valid_q && pop_ready;
        rd_issue   = !flush && !rd_pend_q && (ram_cnt_q != '0)
                     && (!out_valid_q || pop_fire);
        // rst_n gating keeps the producer stalled while reset is held
        push_ready = rst_n && !flush && !rd_issue && (ram_cnt_q != CNT_FULL);
        push_fire  = push_valid && push_ready;

        if (rd_issue) begin
            op = OP_READ;
        end else if (push_fire) begin
            op = OP_WRITE;
        end else begin
            op = OP_IDLE;
        end
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        ram_cnt_d   = ram_cnt_q;
        rd_pend_d   = rd_issue;
        out_valid_d = out_valid_q;
        pop_data_d  = pop_data_q;

        unique case (op)
            OP_READ: begin
                rd_ptr_d  = rd_ptr_q + PTR_ONE;
                ram_cnt_d = ram_cnt_q - CNT_ONE;
            end
            OP_WRITE: begin
                wr_ptr_d  = wr_ptr_q + PTR_ONE;
                ram_cnt_d = ram_cnt_q + CNT_ONE;
            end
            default: begin
            end
        endcase

        if (rd_pend_q && !flush) begin
            pop_data_d  = ram_dout;
            out_valid_d = 1'b1;
        end else if (pop_fire) begin
            out_valid_d = 1'b0;
        end

        // flush drops contents but leaves the last presented word visible
        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            ram_cnt_d   = '0;
            rd_pend_d   = 1'b0;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ram_cnt_q   <= '0;
            rd_pend_q   <= 1'b0;
            out_valid_q <= 1'b0;
            pop_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ram_cnt_q   <= ram_cnt_d;
            rd_pend_q   <= rd_pend_d;
            out_valid_q <= out_valid_d;
            pop_data_q  <= pop_data_d;
        end
    end

    assign ram_we    = (op == OP_WRITE);
    assign ram_addr  = (op == OP_WRITE) ? wr_ptr_q : rd_ptr_q;
    assign ram_din   = push_data;
    assign pop_valid = out_valid_q;
    assign pop_data  = pop_data_q;
    assign count     = ram_cnt_q + CW'(rd_pend_q) + CW'(out_valid_q);

endmodule

// File: tb/tb_spram_fifo_ctrl.sv
// Bench for spram_fifo_ctrl: behavioural RAM plus a queue model of
// the words held, directed scenarios and randomized streaming.
module tb_spram_fifo_ctrl;

    localparam int DW = 8;
    localparam int DEPTH = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          push_valid = 1'b0;
    logic          push_ready;
    logic [DW-1:0] push_data = '0;
    logic          pop_valid;
    logic          pop_ready = 1'b0;
    logic [DW-1:0] pop_data;
    logic [AW:0]   count;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] dout_q;

    logic [DW-1:0] q[$];
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int stall = 0;
    logic acc;
    logic pvs;
    logic popped;

    spram_fifo_ctrl #(
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .flush(flush),
        .push_valid(push_valid),
        .push_ready(push_ready),
        .push_data(push_data),
        .pop_valid(pop_valid),
        .pop_ready(pop_ready),
        .pop_data(pop_data),
        .count(count),
        .ram_we(ram_we),
        .ram_addr(ram_addr),
        .ram_din(ram_din),
        .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        dout_q <= mem[ram_addr];
    end
    assign ram_dout = dout_q;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic pv, input logic [DW-1:0] pd,
                         input logic pr, input logic fl);
        push_valid = pv;
        push_data = pd;
        pop_ready = pr;
        flush = fl;
        #2;
        pvs = pop_valid;
        acc = pv && push_ready;
        popped = pop_valid && pr;
        check("count", 32'(count), 32'(q.size()));
        if (count == '0) check("empty_pop_valid", 32'(pop_valid), 32'(0));
        check("ram_we", 32'(ram_we), 32'(acc));
        if (ram_we) check("ram_din", 32'(ram_din), 32'(pd));
        if (fl) check("flush_push_ready", 32'(push_ready), 32'(0));
        if (popped) begin
            if (q.size() == 0) begin
                check("pop_when_empty", 32'(pop_valid), 32'(0));
            end else begin
                check("pop_data", 32'(pop_data), 32'(q[0]));
                void'(q.pop_front());
            end
        end
        if (pv && !push_ready && !fl && q.size() < DEPTH) stall++;
        else stall = 0;
        if (stall > 1) check("write_starved", 32'(stall), 32'(1));
        if (acc) q.push_back(pd);
        if (fl) q.delete();
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic lat_check(input string tag);
        int first;
        first = -1;
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b0, '0, 1'b1, 1'b0);
            if (pvs && first < 0) first = i;
        end
        check(tag, 32'(first), 32'(3));
        check({tag, "_count"}, 32'(count), 32'(0));
    endtask

    initial begin
        int n;
        int ncyc;
        int last;

        push_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pop_valid", 32'(pop_valid), 32'(0));
        check("rst_count", 32'(count), 32'(0));
        check("rst_ram_we", 32'(ram_we), 32'(0));
        check("rst_ram_addr", 32'(ram_addr), 32'(0));
        check("rst_push_ready", 32'(push_ready), 32'(0));
        check("rst_pop_data", 32'(pop_data), 32'(0));
        @(negedge clk);
        push_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single word from empty
        cycle(1'b1, 8'h11, 1'b1, 1'b0);
        lat_check("latency_first");

        // fill with consumer stalled
        n = 0;
        ncyc = 0;
        while (n < 17 && ncyc < 40) begin
            cycle(1'b1, 8'(8'h20 + n), 1'b0, 1'b0);
            if (acc) n++;
            ncyc++;
        end
        check("fill_accepted", 32'(n), 32'(17));
        check("fill_cycles", 32'(ncyc), 32'(18));
        check("full_count", 32'(count), 32'(17));
        cycle(1'b1, 8'h99, 1'b0, 1'b0);
        check("full_push_ready", 32'(acc), 32'(0));

        // drain at full rate
        n = 0;
        ncyc = 0;
        last = -1;
        while (q.size() > 0 && ncyc < 80) begin
            cycle(1'b0, '0, 1'b1, 1'b0);
            if (popped) begin
                n++;
                if (last >= 0) check("pop_gap", 32'(cyc - 1 - last), 32'(2));
                last = cyc - 1;
            end
            ncyc++;
        end
        check("drain_pops", 32'(n), 32'(17));
        check("drain_count", 32'(count), 32'(0));

        // continuous streaming across pointer wrap
        n = 0;
        ncyc = 0;
        while (n < 40 && ncyc < 200) begin
            cycle(1'b1, 8'($urandom), 1'b1, 1'b0);
            if (acc) n++;
            ncyc++;
        end
        check("stream_accepted", 32'(n), 32'(40));

        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 8'($urandom),
                  1'($urandom_range(0, 2) != 0), 1'b0);
        end
        ncyc = 0;
        while (q.size() > 0 && ncyc < 80) begin
            cycle(1'b0, '0, 1'b1, 1'b0);
            ncyc++;
        end
        check("random_drained", 32'(count), 32'(0));

        // flush with five words held
        n = 0;
        ncyc = 0;
        while (q.size() < 5 && ncyc < 30) begin
            cycle(1'b1, 8'(8'h40 + n), 1'b0, 1'b0);
            if (acc) n++;
            ncyc++;
        end
        check("pre_flush_count", 32'(count), 32'(5));
        cycle(1'b1, 8'hAA, 1'b0, 1'b1);
        check("post_flush_count", 32'(count), 32'(0));
        check("post_flush_pop_valid", 32'(pop_valid), 32'(0));
        check("post_flush_pop_data", 32'(pop_data), 32'(8'h40));
        cycle(1'b1, 8'h5A, 1'b1, 1'b0);
        lat_check("latency_after_flush");

        // reset while a read is in flight
        cycle(1'b1, 8'h77, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        check("pre_reset_count", 32'(count), 32'(1));
        push_valid = 1'b1;
        pop_ready = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_pop_valid", 32'(pop_valid), 32'(0));
        check("mid_rst_count", 32'(count), 32'(0));
        check("mid_rst_ram_we", 32'(ram_we), 32'(0));
        check("mid_rst_ram_addr", 32'(ram_addr), 32'(0));
        check("mid_rst_push_ready", 32'(push_ready), 32'(0));
        q.delete();
        stall = 0;
        @(posedge clk);
        @(negedge clk);
        push_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, '0, 1'b1, 1'b0);
            check("no_stale_word", 32'(pvs), 32'(0));
        end
        cycle(1'b1, 8'h3C, 1'b1, 1'b0);
        lat_check("latency_after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
